// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a start/done handshake, a multi-cycle
// shift-add multiplier and zero/carry/overflow flags.
// Single-cycle ops finish one cycle after start; MUL takes WIDTH+1 cycles.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] ALU_out,
  output logic [WIDTH-1:0] ALU_out_hi,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             ovf_flag
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int ACC_W = 2 * WIDTH;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state;
  state_e           next_state;

  // Multiply working registers: multiplicand, shifting multiplier,
  // double-width accumulator and remaining-iteration counter.
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] mult;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  // Single-cycle datapath results.
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] neg_b;
  logic [WIDTH-1:0] sub_res;
  logic             slt_bit;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;

  // Multiply step results.
  logic [WIDTH:0]   mul_sum;
  logic [ACC_W-1:0] acc_next;
  logic             mul_last;

  // Single-cycle operations computed straight from the live inputs; they
  // are only captured on the cycle a start is accepted.
  always_comb begin
    add_sum   = {1'b0, reg1} + {1'b0, reg2};
    neg_b     = ~reg2 + WIDTH'(1);
    sub_res   = reg1 + neg_b;
    slt_bit   = ($signed(reg1) < $signed(reg2));
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (alu_opcode)
      OP_ADD: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_carry = add_sum[WIDTH];
        alu_ovf   = (reg1[WIDTH-1] == reg2[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != reg1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = sub_res;
        alu_carry = (reg1 < reg2);
        alu_ovf   = (reg1[WIDTH-1] == neg_b[WIDTH-1]) &&
                    (sub_res[WIDTH-1] != reg1[WIDTH-1]);
      end
      OP_AND: alu_res = reg1 & reg2;
      OP_OR:  alu_res = reg1 | reg2;
      OP_XOR: alu_res = reg1 ^ reg2;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_MOV: alu_res = reg1;
      default: alu_res = '0;
    endcase
  end

  // One shift-add iteration: conditionally add the multiplicand into the
  // upper half, then shift {carry, accumulator} right by one.
  always_comb begin
    mul_sum  = {1'b0, acc[ACC_W-1:WIDTH]} + (mult[0] ? {1'b0, op_a} : '0);
    acc_next = ACC_W'({mul_sum, acc[WIDTH-1:0]} >> 1);
    mul_last = (cnt == CNT_W'(1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs; ready/done follow the state directly.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          next_state = (alu_opcode == OP_MUL) ? S_MUL : S_DONE;
        end
      end
      S_MUL: begin
        if (mul_last) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Operand capture, multiply iterations and result/flag registers; the
  // visible outputs change only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      mult       <= '0;
      acc        <= '0;
      cnt        <= '0;
      ALU_out    <= '0;
      ALU_out_hi <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (alu_opcode == OP_MUL) begin
              op_a <= reg1;
              mult <= reg2;
              acc  <= '0;
              cnt  <= CNT_W'(WIDTH);
            end else begin
              ALU_out    <= alu_res;
              ALU_out_hi <= '0;
              zero_flag  <= (alu_res == '0);
              carry_flag <= alu_carry;
              ovf_flag   <= alu_ovf;
            end
          end
        end
        S_MUL: begin
          acc  <= acc_next;
          mult <= mult >> 1;
          cnt  <= cnt - CNT_W'(1);
          if (mul_last) begin
            ALU_out    <= acc_next[WIDTH-1:0];
            ALU_out_hi <= acc_next[ACC_W-1:WIDTH];
            zero_flag  <= (acc_next == '0);
            carry_flag <= 1'b0;
            ovf_flag   <= (acc_next[ACC_W-1:WIDTH] != '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: drives a WIDTH=4 and a WIDTH=8 alu_seq with directed vectors,
// checks every cycle against an arithmetic reference model and pins key
// results with hand-computed literals.
module tb_alu_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic       in_start [2];
  logic [2:0] in_op    [2];
  logic [7:0] in_a     [2];
  logic [7:0] in_b     [2];

  logic       rdy4, done4, z4, c4, v4;
  logic [3:0] lo4, hi4;
  logic       rdy8, done8, z8, c8, v8;
  logic [7:0] lo8, hi8;

  logic       o_rdy  [2];
  logic       o_done [2];
  logic [7:0] o_lo   [2];
  logic [7:0] o_hi   [2];
  logic       o_z    [2];
  logic       o_c    [2];
  logic       o_v    [2];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state
  bit         m_busy [2] = '{0, 0};
  int         m_wait [2] = '{0, 0};
  logic [7:0] p_lo [2] = '{0, 0};
  logic [7:0] p_hi [2] = '{0, 0};
  bit         p_z  [2] = '{0, 0};
  bit         p_c  [2] = '{0, 0};
  bit         p_v  [2] = '{0, 0};
  logic [7:0] e_lo [2] = '{0, 0};
  logic [7:0] e_hi [2] = '{0, 0};
  bit         e_z  [2] = '{0, 0};
  bit         e_c  [2] = '{0, 0};
  bit         e_v  [2] = '{0, 0};
  logic [7:0] t_lo, t_hi;
  bit         t_z, t_c, t_v;

  // Hand-computed vectors
  int         sw_lo  [8] = '{9, 15, 4, 5, 1, 4, 1, 4};
  int         sw_hi  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
  logic [2:0] sw_f   [8] = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
  int         sw_lat [8] = '{1, 1, 1, 1, 1, 5, 1, 1};
  int         fib    [13] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121};
  logic [2:0] fib_f  [13] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                              3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b011};

  alu_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(in_start[0]), .alu_opcode(in_op[0]),
    .reg1(in_a[0][3:0]), .reg2(in_b[0][3:0]), .ready(rdy4), .done(done4),
    .ALU_out(lo4), .ALU_out_hi(hi4), .zero_flag(z4), .carry_flag(c4), .ovf_flag(v4)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(in_start[1]), .alu_opcode(in_op[1]),
    .reg1(in_a[1]), .reg2(in_b[1]), .ready(rdy8), .done(done8),
    .ALU_out(lo8), .ALU_out_hi(hi8), .zero_flag(z8), .carry_flag(c8), .ovf_flag(v8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    o_rdy[0]  = rdy4;  o_done[0] = done4;
    o_lo[0]   = {4'b0000, lo4};
    o_hi[0]   = {4'b0000, hi4};
    o_z[0]    = z4;  o_c[0] = c4;  o_v[0] = v4;
    o_rdy[1]  = rdy8;  o_done[1] = done8;
    o_lo[1]   = lo8;
    o_hi[1]   = hi8;
    o_z[1]    = z8;  o_c[1] = c8;  o_v[1] = v8;
  end

  function automatic int wd(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  // Result of one operation from plain integer arithmetic
  function automatic void model_op(input int w, input int op, input int a_in, input int b_in,
                                   output logic [7:0] lo, output logic [7:0] hi,
                                   output bit z, output bit c, output bit v);
    int mask, msb, a, b, sa, sb, r, nb;
    mask = (1 << w) - 1;
    msb  = 1 << (w - 1);
    a    = a_in & mask;
    b    = b_in & mask;
    sa   = ((a & msb) != 0) ? a - (1 << w) : a;
    sb   = ((b & msb) != 0) ? b - (1 << w) : b;
    hi   = '0;
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      0: begin
        r = a + b;
        c = (r > mask);
        v = ((sa + sb) > (msb - 1)) || ((sa + sb) < -msb);
      end
      1: begin
        r  = a - b;
        c  = (a < b);
        nb = (-b) & mask;
        v  = (((a ^ nb) & msb) == 0) && ((((r & mask) ^ a) & msb) != 0);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin
        r  = a * b;
        hi = 8'((r >> w) & mask);
        v  = (((r >> w) & mask) != 0);
      end
      6: r = (sa < sb) ? 1 : 0;
      default: r = a;
    endcase
    lo = 8'(r & mask);
    z  = (op == 5) ? (r == 0) : ((r & mask) == 0);
  endfunction

  // Model timeline: accept when idle, count down the latency, publish results
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0; m_wait[i] = 0;
        e_lo[i] = '0; e_hi[i] = '0; e_z[i] = 1'b0; e_c[i] = 1'b0; e_v[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (in_start[i] === 1'b1) begin
            model_op(wd(i), int'(in_op[i]), int'(in_a[i]), int'(in_b[i]), t_lo, t_hi, t_z, t_c, t_v);
            p_lo[i] = t_lo; p_hi[i] = t_hi; p_z[i] = t_z; p_c[i] = t_c; p_v[i] = t_v;
            m_busy[i] = 1'b1;
            m_wait[i] = (in_op[i] == 3'd5) ? wd(i) : 0;
          end
        end else if (m_wait[i] == 0) begin
          m_busy[i] = 1'b0;
        end else begin
          m_wait[i] = m_wait[i] - 1;
        end
        if (m_busy[i] && m_wait[i] == 0) begin
          e_lo[i] = p_lo[i]; e_hi[i] = p_hi[i];
          e_z[i]  = p_z[i];  e_c[i]  = p_c[i];  e_v[i] = p_v[i];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("w%0d ready", wd(i)), o_rdy[i], !m_busy[i]);
      checkOutput($sformatf("w%0d done", wd(i)), o_done[i], m_busy[i] && (m_wait[i] == 0));
      checkOutput($sformatf("w%0d ALU_out", wd(i)), o_lo[i], e_lo[i]);
      checkOutput($sformatf("w%0d ALU_out_hi", wd(i)), o_hi[i], e_hi[i]);
      checkOutput($sformatf("w%0d zero_flag", wd(i)), o_z[i], e_z[i]);
      checkOutput($sformatf("w%0d carry_flag", wd(i)), o_c[i], e_c[i]);
      checkOutput($sformatf("w%0d ovf_flag", wd(i)), o_v[i], e_v[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int i, input int op, input int a, input int b);
    in_start[i] = 1'b1;
    in_op[i]    = 3'(op);
    in_a[i]     = 8'(a);
    in_b[i]     = 8'(b);
    tick();
    in_start[i] = 1'b0;
  endtask

  task automatic waitDone(input int i, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (o_done[i] === 1'b1) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL w%0d done timeout: done=0 after 40 cycles, expected done=1", wd(i));
    end
  endtask

  task automatic checkResult(input int i, input string tag, input int lat, input int x_lo,
                             input int x_hi, input logic [2:0] x_f, input int x_lat);
    checkOutput({tag, " lo"}, o_lo[i], 64'(x_lo));
    checkOutput({tag, " hi"}, o_hi[i], 64'(x_hi));
    checkOutput({tag, " zcv"}, {o_z[i], o_c[i], o_v[i]}, x_f);
    checkOutput({tag, " latency"}, 64'(lat), 64'(x_lat));
  endtask

  task automatic runOp(input int i, input int op, input int a, input int b, input int x_lo,
                       input int x_hi, input logic [2:0] x_f, input int x_lat);
    int c0;
    bit ok;
    c0 = cyc;
    applyStimulus(i, op, a, b);
    waitDone(i, ok);
    if (ok) checkResult(i, $sformatf("w%0d op%0d %0d,%0d", wd(i), op, a, b), cyc - c0, x_lo, x_hi, x_f, x_lat);
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  c0;
    bit  ok;
    int  x, y;
    for (int i = 0; i < 2; i++) begin
      in_start[i] = 1'b0; in_op[i] = 3'd0; in_a[i] = 8'd0; in_b[i] = 8'd0;
    end
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset state
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("rst w%0d ready", wd(i)), o_rdy[i], 1);
      checkOutput($sformatf("rst w%0d done", wd(i)), o_done[i], 0);
      checkOutput($sformatf("rst w%0d lo/hi", wd(i)), {o_lo[i], o_hi[i]}, 0);
      checkOutput($sformatf("rst w%0d zcv", wd(i)), {o_z[i], o_c[i], o_v[i]}, 0);
    end
    repeat (5) begin
      tick();
      checkOutput("idle w4 done", o_done[0], 0);
      checkOutput("idle w8 done", o_done[1], 0);
    end

    // WIDTH=4 opcode sweep, back-to-back
    for (int k = 0; k < 8; k++) runOp(0, k, 4, 5, sw_lo[k], sw_hi[k], sw_f[k], sw_lat[k]);

    // Zero/carry edges
    runOp(0, 0, 15, 1, 0, 0, 3'b110, 1);
    runOp(0, 1, 7, 7, 0, 0, 3'b100, 1);
    runOp(0, 5, 0, 9, 0, 0, 3'b100, 5);

    // Handshake: ignored starts while busy, operands changed after accept
    c0 = cyc;
    applyStimulus(1, 5, 200, 3);
    in_a[1] = 8'd7; in_b[1] = 8'd9; in_op[1] = 3'd0;
    tick();
    in_start[1] = 1'b1; tick(); in_start[1] = 1'b0;
    tick(); tick();
    in_start[1] = 1'b1; tick(); in_start[1] = 1'b0;
    waitDone(1, ok);
    if (ok) checkResult(1, "w8 mul 200*3", cyc - c0, 8'h58, 8'h02, 3'b001, 9);
    tick();

    // Reset in the middle of a multiply
    applyStimulus(1, 5, 255, 255);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rst w8 lo/hi", {o_lo[1], o_hi[1]}, 0);
    checkOutput("async rst w8 zcv", {o_z[1], o_c[1], o_v[1]}, 0);
    checkOutput("async rst w8 ready", o_rdy[1], 1);
    checkOutput("async rst w8 done", o_done[1], 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    repeat (3) begin
      checkOutput("post rst w8 ready", o_rdy[1], 1);
      tick();
    end
    runOp(1, 5, 255, 255, 8'h01, 8'hFE, 3'b001, 9);

    // Fibonacci with ADD and MOV
    x = 0;
    y = 1;
    for (int k = 0; k < 13; k++) begin
      runOp(1, 0, x, y, fib[k], 0, fib_f[k], 1);
      if (k < 12) runOp(1, 7, y, 0, y, 0, 3'b000, 1);
      x = y;
      y = fib[k];
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the 4-bit combinational ALU used by the Fibonacci datapath.
- Adds a start/done handshake, a multi-cycle shift-add multiply, and carry/overflow flags alongside the zero flag.
- Sits between the register file and the Fibonacci control FSM. The FSM issues one operation at a time and waits for done.

Parameters:
- WIDTH, 4, operand/result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), multiply iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when ready=1
- alu_opcode  input  3  operation select, sampled with start
- reg1  input  WIDTH  operand A, sampled with start
- reg2  input  WIDTH  operand B, sampled with start
- ready  output  1  high in IDLE; block can accept start
- done  output  1  one-cycle pulse; result and flags valid from this cycle
- ALU_out  output  WIDTH  result (low half of product for MUL)
- ALU_out_hi  output  WIDTH  high half of product for MUL; 0 for all other ops
- zero_flag  output  1  ALU_out == 0 (MUL: the full 2*WIDTH product == 0)
- carry_flag  output  1  ADD: carry out; SUB: borrow (reg1 < reg2 unsigned); else 0
- ovf_flag  output  1  ADD/SUB: signed two's-complement overflow; MUL: ALU_out_hi != 0; else 0

Behaviour:
- Reset (async, rst_n=0): state IDLE; ready=1; done=0; ALU_out, ALU_out_hi and all flags = 0; operand and counter registers = 0.
- Opcodes:
  - 000 ADD: A+B
  - 001 SUB: A-B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 MUL: unsigned A*B
  - 110 SLT: 1 if A<B signed, else 0
  - 111 MOV: pass A
- Arithmetic results wrap modulo 2^WIDTH.
- States: IDLE, MUL, DONE.
  - IDLE: start=1 with a non-MUL opcode → compute from the sampled inputs, register result and flags, go to DONE.
  - IDLE: start=1 with opcode 101 → latch A and B, clear the 2*WIDTH accumulator, load counter = WIDTH, go to MUL.
  - MUL: each cycle, if the current multiplier LSB is 1, add the multiplicand into the upper accumulator half. Then shift the {carry, accumulator} right by 1 and decrement the counter. When the counter reaches 0, register the outputs and go to DONE.
  - DONE: done=1 for exactly one cycle, ready=0; return to IDLE.
- Latency (start cycle = cycle 0):
  - non-MUL: done at cycle 1.
  - MUL: done at cycle WIDTH+1.
  - ready returns high the cycle after done.
  - Back-to-back issue is allowed: start on the cycle ready returns is accepted.
- start while ready=0 is ignored; it has no effect on the operation in flight and is not queued.
- reg1, reg2 and alu_opcode may change freely after the start cycle; only the values sampled at the accepted start are used.
- ALU_out, ALU_out_hi and the flags hold their last values until the next done; they update only on the cycle done rises.
- Asserting rst_n=0 mid-MUL aborts the operation. All outputs return to reset values and no done is produced.
- SLT uses signed compare of WIDTH-bit operands. ADD/SUB overflow = sign(A) and sign(B') agree and differ from sign(result), where B' = B for ADD and ~B+1 for SUB.

Test Plan:
- Reset/idle:
  - Apply rst_n=0 for 2 cycles, then release.
  - Expect ready=1, done=0, ALU_out=0, ALU_out_hi=0 and all flags 0.
  - Hold start=0 for 5 cycles; expect no done pulse.
- WIDTH=4 sweep:
  - Set reg1=4'b0100, reg2=4'b0101 and issue opcodes 000..111 back-to-back.
  - Expected ALU_out: ADD 9 (carry 0, ovf 1), SUB 15 (carry 1, ovf 0), AND 4, OR 5, XOR 1, MUL 4 (ALU_out_hi=1, ovf 1), SLT 1, MOV 4.
  - done arrives at cycle 1 for every op except MUL, which is at cycle 5.
- Zero/carry edges, WIDTH=4:
  - ADD 15+1 → ALU_out=0, zero_flag=1, carry_flag=1.
  - SUB 7-7 → zero_flag=1, carry_flag=0.
  - MUL 0*9 → zero_flag=1, ALU_out_hi=0.
- Handshake robustness:
  - WIDTH=8: MUL 200*3, then pulse start with ADD at cycles 2 and 5.
  - Expect the ADDs ignored; done at cycle 9 with ALU_out=0x58 and ALU_out_hi=0x02.
  - Operands changed after cycle 0 must not affect the result.
- Reset mid-operation:
  - WIDTH=8: start MUL 255*255, assert rst_n=0 at cycle 4.
  - Expect outputs 0 immediately (asynchronous), no done, and ready=1 after release.
  - A following MUL 255*255 gives ALU_out=0x01, ALU_out_hi=0xFE.
- Fibonacci sequence, WIDTH=8:
  - Drive repeated ADD and MOV from 0,1 for 14 terms.
  - Expect ALU_out sequence 1,2,3,5,…,233, then 377 mod 256 = 121 with carry_flag=1 on the wrap.
